// File: rtl/fir_axilite_ctrl.sv
// fir_axilite_ctrl: AXI-Lite register and tap-RAM front end with the ap_ctrl start/done sequencer.
module fir_axilite_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    input  logic                   eng_done,
    output logic                   ap_start_o,
    output logic [31:0]            data_length
);
    typedef enum logic {W_IDLE, W_ACK} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} c_state_e;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'(72);

    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    c_state_e               c_state_q, c_state_d;
    logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                   rd_ok_q, rd_ok_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]            len_q, len_d;
    logic                   start_q, start_d;
    logic                   ap_idle, ap_done, wr_commit, wr_tap, rd_tap, rd_accept, ctrl_rd_done;

    assign ap_idle      = c_state_q != C_RUN;
    assign ap_done      = c_state_q == C_DONE;
    assign wr_commit    = w_state_q == W_ACK;
    assign wr_tap       = wr_commit && ap_idle && awaddr >= ADDR_TAP0 && awaddr <= ADDR_TAPN;
    assign rd_tap       = araddr >= ADDR_TAP0 && araddr <= ADDR_TAPN;
    // a tap read colliding with a tap write to a different address waits a cycle for the single RAM port
    assign rd_accept    = axis_rst_n && r_state_q == R_IDLE && arvalid && !(wr_tap && rd_tap && araddr != awaddr);
    assign ctrl_rd_done = r_state_q == R_DATA && rready && raddr_q == ADDR_CTRL;

    always_comb begin
        w_state_d = (w_state_q == W_IDLE && awvalid && wvalid) ? W_ACK : W_IDLE;
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rd_ok_d   = rd_ok_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: if (rd_accept) begin
                r_state_d = R_ADDR;
                raddr_d   = araddr;
                rd_ok_d   = ap_idle && rd_tap;
            end
            R_ADDR: begin
                r_state_d = R_DATA;
                rdata_d   = raddr_q == ADDR_CTRL ? pDATA_WIDTH'({ap_idle, ap_done, 1'b0})
                          : raddr_q == ADDR_LEN  ? pDATA_WIDTH'(len_q)
                          : (raddr_q >= ADDR_TAP0 && raddr_q <= ADDR_TAPN) ? (rd_ok_q ? tap_Do : '1)
                          : '0;
            end
            default: if (rready) r_state_d = R_IDLE;
        endcase
        len_d     = (wr_commit && ap_idle && awaddr == ADDR_LEN) ? 32'(wdata) : len_q;
        start_d   = wr_commit && ap_idle && awaddr == ADDR_CTRL && wdata[0];
        c_state_d = start_d ? C_RUN
                  : (c_state_q == C_RUN && eng_done) ? C_DONE
                  : (c_state_q == C_DONE && ctrl_rd_done) ? C_IDLE
                  : c_state_q;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            c_state_q <= C_IDLE;
            raddr_q   <= '0;
            rd_ok_q   <= 1'b0;
            rdata_q   <= '0;
            len_q     <= '0;
            start_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            c_state_q <= c_state_d;
            raddr_q   <= raddr_d;
            rd_ok_q   <= rd_ok_d;
            rdata_q   <= rdata_d;
            len_q     <= len_d;
            start_q   <= start_d;
        end
    end

    assign awready     = wr_commit;
    assign wready      = wr_commit;
    assign arready     = rd_accept;
    assign rvalid      = r_state_q == R_DATA;
    assign rdata       = rdata_q;
    assign ap_start_o  = start_q;
    assign data_length = len_q;
    assign tap_EN      = axis_rst_n && (!ap_idle || wr_tap || (rd_accept && rd_tap));
    assign tap_WE      = (axis_rst_n && wr_tap) ? 4'hF : 4'h0;
    assign tap_A       = !ap_idle ? eng_tap_A : wr_tap ? awaddr - ADDR_TAP0 : araddr - ADDR_TAP0;
    assign tap_Di      = wdata;
endmodule
